// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end.
// Owns the fetch PC, issues one word request at a time over a req/ack
// handshake, buffers returned words with their PC+4 in a DEPTH-entry FIFO
// and presents the FIFO head to IF/ID. Redirects flush the queue and
// discard any in-flight response.
// Optional feature macro: FETCH_PREFETCH_STATS_EN adds saturating
// statistics counters (stat_fetched, stat_flushed, stat_empty).
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        init_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_npc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
  output logic [31:0] stat_empty
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_req_addr;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_fifo_inst [DEPTH];
  logic [31:0]     r_fifo_npc  [DEPTH];

  logic            w_issue;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic [31:0]     w_req_npc;

  // The request stays asserted from WAIT/DROP entry until the ack,
  // so the address held on the bus is always the latched request address.
  assign mem_req   = (r_state == S_WAIT) || (r_state == S_DROP);
  assign mem_addr  = mem_req ? r_req_addr : r_pc;

  assign out_valid = (r_count != '0);
  assign out_inst  = out_valid ? r_fifo_inst[r_rptr] : NOP_INST;
  assign out_npc   = out_valid ? r_fifo_npc[r_rptr]  : 32'h0000_0000;

  // A redirect flushes in the same edge, so it must also suppress the pop.
  assign w_pop     = out_valid && out_ready && !redirect;
  assign w_req_npc = r_req_addr + 32'd4;

  // FSM state register
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // FSM next state plus issue/push/drop strobes; a request is only issued
  // when a FIFO slot is free, so a returning ack never meets a full queue
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect && (r_count < DEPTH_C)) begin
          w_next_state = S_WAIT;
          w_issue      = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_next_state = S_IDLE;
          if (redirect) w_drop = 1'b1;
          else          w_push = 1'b1;
        end else if (redirect) begin
          w_next_state = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack) begin
          w_next_state = S_IDLE;
          w_drop       = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fetch PC and latched request address
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (redirect)    r_pc <= redirect_pc;
      else if (w_push) r_pc <= w_req_npc;
      if (w_issue)     r_req_addr <= r_pc;
    end
  end

  // FIFO pointers and occupancy; flush wins over same-cycle push and pop
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage: data only, no reset needed since occupancy gates the outputs
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wptr] <= mem_rdata;
      r_fifo_npc[r_wptr]  <= w_req_npc;
    end
  end

`ifdef FETCH_PREFETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;
  logic [31:0] r_stat_empty;
  logic [31:0] w_flush_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Discarded work: queued entries lost to a flush plus any dropped response
  assign w_flush_inc = (redirect ? 32'(r_count) : 32'd0) + (w_drop ? 32'd1 : 32'd0);

  // Saturating statistics counters
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_stat_fetched <= 32'd0;
      r_stat_flushed <= 32'd0;
      r_stat_empty   <= 32'd0;
    end else begin
      if (w_push)                 r_stat_fetched <= sat_add(r_stat_fetched, 32'd1);
      if (w_flush_inc != 32'd0)   r_stat_flushed <= sat_add(r_stat_flushed, w_flush_inc);
      if (!out_valid && out_ready) r_stat_empty  <= sat_add(r_stat_empty, 32'd1);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
  assign stat_empty   = r_stat_empty;
`endif

endmodule
